beat_detector: RTL and testbench

Parametrised successor to the heart-rate hysteresis comparator. It turns a stream of ADC samples into a debounced pulse level and a one-cycle beat strobe, and measures the inter-beat interval (IBI) in samples. A refractory window rejects double-counts, and a timeout flags loss of signal. Sits between the ADC sample interface and the heart-rate averaging/display logic.

---
 rtl/beat_detector_if.sv | 28 ++
 rtl/beat_detector.sv | 153 +++++++++++++++
 tb/tb_beat_detector.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/beat_detector_if.sv
// Sample/result bundle between the ADC sample source and beat_detector.
// Latency: none (wires only). Backpressure: none; samples are qualified by sample_valid alone.
// Ports: master drives sample_valid/din/thresh_hi/thresh_lo and observes the results;
//        slave (the detector) consumes samples and drives pulse/beat/ibi/ibi_valid/timeout.
interface beat_detector_if #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 16
) ();
  logic             sample_valid;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] thresh_hi;
  logic [WIDTH-1:0] thresh_lo;
  logic             pulse;
  logic             beat;
  logic [CNT_W-1:0] ibi;
  logic             ibi_valid;
  logic             timeout;

  modport master (
    output sample_valid, din, thresh_hi, thresh_lo,
    input  pulse, beat, ibi, ibi_valid, timeout
  );

  modport slave (
    input  sample_valid, din, thresh_hi, thresh_lo,
    output pulse, beat, ibi, ibi_valid, timeout
  );
endinterface

// File: rtl/beat_detector.sv
// Hysteresis/dwell beat detector with refractory window, inter-beat interval and loss-of-signal flag.
// Latency: pulse follows the state register; beat/ibi/ibi_valid/timeout are registered one clock after the qualifying sample.
// Backpressure: none; every cycle with sample_valid=1 is consumed, sample_valid=0 freezes all state.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries samples, thresholds and results.
module beat_detector #(
  parameter int WIDTH     = 12,
  parameter int CNT_W     = 16,
  parameter int MIN_DWELL = 4,
  parameter int MIN_IBI   = 250,
  parameter int MAX_IBI   = 3000
) (
  input logic           clk,
  input logic           rst,
  beat_detector_if.slave bus
);

  typedef enum logic [1:0] {LO, RISE, HI, FALL} state_t;

  localparam int                DW      = $clog2(MIN_DWELL + 1);
  localparam logic [DW-1:0]     DWELL   = DW'(MIN_DWELL);
  localparam logic [DW-1:0]     ONE_D   = DW'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  IBI_MIN = CNT_W'(MIN_IBI);
  localparam logic [CNT_W-1:0]  IBI_MAX = CNT_W'(MAX_IBI);

  logic [WIDTH-1:0] din, thi, tlo;
  logic             gt_hi, le_lo;

  state_t           state, state_nxt;
  logic [DW-1:0]    dcnt, dcnt_nxt;
  logic             entry;

  logic [CNT_W-1:0] icnt, n;
  logic             armed;
  logic             beat_q, ibi_valid_q, timeout_q;
  logic [CNT_W-1:0] ibi_q;

  assign din   = bus.din;
  assign thi   = bus.thresh_hi;
  assign tlo   = bus.thresh_lo;
  // Raw compares; threshold ordering is deliberately not enforced.
  assign gt_hi = din > thi;
  assign le_lo = din <= tlo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LO;
      dcnt  <= '0;
    end else if (bus.sample_valid) begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // entry flags the LO/RISE -> HI transition only; FALL -> HI is a glitch recovery, not a beat.
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    entry     = 1'b0;
    case (state)
      LO: if (gt_hi) begin
        if (DWELL == ONE_D) begin
          state_nxt = HI;
          entry     = 1'b1;
          dcnt_nxt  = '0;
        end else begin
          state_nxt = RISE;
          dcnt_nxt  = ONE_D;
        end
      end
      RISE: if (gt_hi) begin
        if (dcnt + ONE_D == DWELL) begin
          state_nxt = HI;
          entry     = 1'b1;
          dcnt_nxt  = '0;
        end else begin
          dcnt_nxt  = dcnt + ONE_D;
        end
      end else begin
        state_nxt = LO;
        dcnt_nxt  = '0;
      end
      HI: if (le_lo) begin
        if (DWELL == ONE_D) begin
          state_nxt = LO;
          dcnt_nxt  = '0;
        end else begin
          state_nxt = FALL;
          dcnt_nxt  = ONE_D;
        end
      end
      FALL: if (le_lo) begin
        if (dcnt + ONE_D == DWELL) begin
          state_nxt = LO;
          dcnt_nxt  = '0;
        end else begin
          dcnt_nxt  = dcnt + ONE_D;
        end
      end else begin
        state_nxt = HI;
        dcnt_nxt  = '0;
      end
      default: begin
        state_nxt = LO;
        dcnt_nxt  = '0;
      end
    endcase
  end

  // Interval including the current sample, saturating at the counter range.
  assign n = (icnt == CNT_MAX) ? icnt : icnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      icnt        <= '0;
      armed       <= 1'b0;
      beat_q      <= 1'b0;
      ibi_valid_q <= 1'b0;
      ibi_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      beat_q      <= 1'b0;
      ibi_valid_q <= 1'b0;
      if (bus.sample_valid) begin
        icnt <= n;
        if (entry) begin
          // Inside the refractory window the edge only moves pulse; interval keeps running.
          if (!(armed && (n < IBI_MIN))) begin
            beat_q <= 1'b1;
            icnt   <= '0;
            if (armed) begin
              ibi_q       <= n;
              ibi_valid_q <= 1'b1;
            end
          end
          armed     <= 1'b1;
          timeout_q <= 1'b0;
        end else if (n >= IBI_MAX) begin
          // Disarm so the interval spanning the dropout is never reported.
          timeout_q <= 1'b1;
          armed     <= 1'b0;
        end
      end
    end
  end

  assign bus.pulse     = (state == HI) || (state == FALL);
  assign bus.beat      = beat_q;
  assign bus.ibi_valid = ibi_valid_q;
  assign bus.ibi       = ibi_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_beat_detector.sv
// Self-checking bench for beat_detector: directed segment table, reset corner sequence, randomized run.
// Latency: outputs sampled on the falling edge after each driven sample.
// Backpressure: none; sample_valid is toggled randomly to exercise hold cycles.
module tb_beat_detector;
  localparam int WIDTH     = 12;
  localparam int CNT_W     = 16;
  localparam int MIN_DWELL = 4;
  localparam int MIN_IBI   = 250;
  localparam int MAX_IBI   = 3000;
  localparam int SAT       = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  beat_detector_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  beat_detector #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .MIN_DWELL(MIN_DWELL),
    .MIN_IBI(MIN_IBI), .MAX_IBI(MAX_IBI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int th_hi, th_lo;
  int seg_beats, seg_ibvs;

  // Reference: run-length of samples pushing toward the opposite level, and a
  // plain "samples since last accepted beat" count.
  bit m_level, m_armed, m_to, m_beat, m_ibv;
  int m_run, m_since, m_ibi;

  typedef struct {
    bit valid;
    int din;
    int len;
    bit pulse;
    int beats;
    int ibvs;
    int ibi;
    bit to;
  } seg_t;
  seg_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_armed = 0; m_to = 0; m_beat = 0; m_ibv = 0;
    m_run = 0; m_since = 0; m_ibi = 0;
  endtask

  task automatic model_sample(input int d);
    bit q, entry;
    entry = 0;
    q = m_level ? (d <= th_lo) : (d > th_hi);
    if (q) begin
      m_run++;
      if (m_run == MIN_DWELL) begin
        m_level = !m_level;
        m_run   = 0;
        entry   = m_level;
      end
    end else begin
      m_run = 0;
    end
    if (m_since < SAT) m_since++;
    if (entry) begin
      if (!(m_armed && m_since < MIN_IBI)) begin
        m_beat = 1;
        if (m_armed) begin
          m_ibi = m_since;
          m_ibv = 1;
        end
        m_since = 0;
      end
      m_armed = 1;
      m_to    = 0;
    end else if (m_since >= MAX_IBI) begin
      m_to    = 1;
      m_armed = 0;
    end
  endtask

  task automatic step(input bit v, input int d);
    bus.sample_valid = v;
    bus.din          = WIDTH'(d);
    bus.thresh_hi    = WIDTH'(th_hi);
    bus.thresh_lo    = WIDTH'(th_lo);
    @(posedge clk);
    m_beat = 0;
    m_ibv  = 0;
    if (rst) model_reset();
    else if (v) model_sample(d);
    @(negedge clk);
    check("model_pulse", int'(bus.pulse), int'(m_level));
    check("model_beat", int'(bus.beat), int'(m_beat));
    check("model_ibi_valid", int'(bus.ibi_valid), int'(m_ibv));
    check("model_ibi", int'(bus.ibi), m_ibi);
    check("model_timeout", int'(bus.timeout), int'(m_to));
    if (bus.beat) seg_beats++;
    if (bus.ibi_valid) seg_ibvs++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pulse"}, int'(bus.pulse), 0);
    check({tag, "_beat"}, int'(bus.beat), 0);
    check({tag, "_ibi_valid"}, int'(bus.ibi_valid), 0);
    check({tag, "_ibi"}, int'(bus.ibi), 0);
    check({tag, "_timeout"}, int'(bus.timeout), 0);
  endtask

  initial begin
    th_hi = 2100;
    th_lo = 2000;
    rst   = 1'b1;
    model_reset();
    step(0, 0);
    step(1, 0);
    check_reset_outputs("reset");
    rst = 1'b0;

    //                valid din   len  pulse beats ibvs ibi  to
    tbl.push_back(seg_t'{1, 0,    100,  0, 0, 0, 0,    0});
    tbl.push_back(seg_t'{1, 2200, 3,    0, 0, 0, 0,    0});
    tbl.push_back(seg_t'{1, 1900, 1,    0, 0, 0, 0,    0});
    tbl.push_back(seg_t'{1, 2200, 10,   1, 1, 0, 0,    0});
    tbl.push_back(seg_t'{1, 1900, 290,  0, 0, 0, 0,    0});
    tbl.push_back(seg_t'{1, 2200, 10,   1, 1, 1, 300,  0});
    tbl.push_back(seg_t'{1, 1900, 290,  0, 0, 0, 300,  0});
    tbl.push_back(seg_t'{1, 2200, 10,   1, 1, 1, 300,  0});
    tbl.push_back(seg_t'{1, 1900, 90,   0, 0, 0, 300,  0});
    tbl.push_back(seg_t'{1, 2200, 10,   1, 0, 0, 300,  0});  // edge at 100: refractory
    tbl.push_back(seg_t'{1, 1900, 190,  0, 0, 0, 300,  0});
    tbl.push_back(seg_t'{1, 2200, 10,   1, 1, 1, 300,  0});  // 300 after original beat
    tbl.push_back(seg_t'{1, 1900, 2993, 0, 0, 0, 300,  0});
    tbl.push_back(seg_t'{1, 1900, 1,    0, 0, 0, 300,  1});  // 3000th sample
    tbl.push_back(seg_t'{1, 1900, 20,   0, 0, 0, 300,  1});
    tbl.push_back(seg_t'{1, 2200, 10,   1, 1, 0, 300,  0});  // clears timeout, unarmed
    tbl.push_back(seg_t'{1, 1900, 2990, 0, 0, 0, 300,  0});
    tbl.push_back(seg_t'{1, 2200, 10,   1, 1, 1, 3000, 0});  // beat on timeout sample wins
    tbl.push_back(seg_t'{1, 1900, 239,  0, 0, 0, 3000, 0});
    tbl.push_back(seg_t'{1, 2200, 10,   1, 0, 0, 3000, 0});  // n=249 suppressed
    tbl.push_back(seg_t'{1, 1900, 4,    0, 0, 0, 3000, 0});
    tbl.push_back(seg_t'{1, 2200, 10,   1, 1, 1, 263,  0});
    tbl.push_back(seg_t'{1, 1900, 240,  0, 0, 0, 263,  0});
    tbl.push_back(seg_t'{1, 2200, 10,   1, 1, 1, 250,  0});  // n=250 accepted
    tbl.push_back(seg_t'{1, 1900, 3,    1, 0, 0, 250,  0});  // FALL, dcnt=3
    tbl.push_back(seg_t'{1, 2200, 5,    1, 0, 0, 250,  0});  // back to HI, no beat
    tbl.push_back(seg_t'{1, 1900, 4,    0, 0, 0, 250,  0});
    tbl.push_back(seg_t'{1, 2200, 2,    0, 0, 0, 250,  0});  // RISE, dcnt=2
    tbl.push_back(seg_t'{0, 1900, 5,    0, 0, 0, 250,  0});  // invalid samples hold
    tbl.push_back(seg_t'{1, 2200, 2,    1, 0, 0, 250,  0});  // entry, n=22 suppressed

    for (int i = 0; i < tbl.size(); i++) begin
      seg_beats = 0;
      seg_ibvs  = 0;
      for (int k = 0; k < tbl[i].len; k++) step(tbl[i].valid, tbl[i].din);
      check($sformatf("seg%0d_pulse", i), int'(bus.pulse), int'(tbl[i].pulse));
      check($sformatf("seg%0d_beats", i), seg_beats, tbl[i].beats);
      check($sformatf("seg%0d_ibvs", i), seg_ibvs, tbl[i].ibvs);
      check($sformatf("seg%0d_ibi", i), int'(bus.ibi), tbl[i].ibi);
      check($sformatf("seg%0d_timeout", i), int'(bus.timeout), int'(tbl[i].to));
    end

    // Reset in RISE with dcnt=3, sample_valid high during reset.
    for (int k = 0; k < 4; k++) step(1, 1900);
    for (int k = 0; k < 3; k++) step(1, 2200);
    check("rise3_pulse", int'(bus.pulse), 0);
    rst = 1'b1;
    step(1, 2200);
    check_reset_outputs("midrise_reset");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1, 2200);
      check($sformatf("post_reset_s%0d_pulse", k + 1), int'(bus.pulse), 0);
      check($sformatf("post_reset_s%0d_beat", k + 1), int'(bus.beat), 0);
    end
    step(1, 2200);
    check("post_reset_s4_pulse", int'(bus.pulse), 1);
    check("post_reset_s4_beat", int'(bus.beat), 1);
    check("post_reset_s4_ibi_valid", int'(bus.ibi_valid), 0);
    check("post_reset_s4_ibi", int'(bus.ibi), 0);

    // Randomized runs against the reference model.
    begin
      int cyc, len, mode, d;
      cyc = 0;
      while (cyc < 20000) begin
        th_hi = int'($urandom_range(500, 3500));
        if ($urandom_range(0, 4) == 0) th_lo = int'($urandom_range(500, 3500));
        else th_lo = th_hi - int'($urandom_range(0, 300));
        if ($urandom_range(0, 3) == 0) len = int'($urandom_range(50, 600));
        else len = int'($urandom_range(1, 7));
        mode = int'($urandom_range(0, 4));
        for (int k = 0; k < len; k++) begin
          case (mode)
            0:       d = int'($urandom_range(th_hi + 1, 4095));
            1:       d = int'($urandom_range(0, th_lo));
            2:       d = int'($urandom_range(0, 4095));
            3:       d = (k % 2 == 1) ? th_hi : th_lo;
            default: d = th_hi + 1;
          endcase
          step($urandom_range(0, 7) != 0, d);
          cyc++;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
